// File: rtl/mips_bus_lsu_if.sv
// Signal bundle between the load/store unit, the core request side and the Avalon-style memory bus.
// Core side: a request transfers on a rising edge with req_valid && req_ready; resp_valid is a one-cycle pulse.
// Bus side: a read/write strobe transfers on a rising edge with waitrequest low, and is held stable until then.
interface mips_bus_lsu_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] address;
    logic        read;
    logic        write;
    logic        waitrequest;
    logic [3:0]  byteenable;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
        output req_ready, resp_valid, resp_rdata, resp_err,
        output address, read, write, byteenable, writedata,
        input  waitrequest, readdata
    );

    modport slave (
        output req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata, resp_err,
        input  address, read, write, byteenable, writedata,
        output waitrequest, readdata
    );
endinterface

// File: rtl/mips_bus_lsu.sv
// Single-outstanding load/store initiator: turns byte/half/word core requests into word-aligned
// bus transactions with lane enables, and returns extracted, sign/zero-extended load data.
module mips_bus_lsu #(
    parameter int READ_LATENCY = 1
) (
    input  logic           clk,
    input  logic           reset,
    mips_bus_lsu_if.master bus,
    output logic [2:0]     dbg_state
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        RD_REQ   = 3'd1,
        RD_DATA  = 3'd2,
        WR_REQ   = 3'd3,
        RESP_ERR = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic [3:0]  be_q, be_d;
    logic        read_q, read_d;
    logic        write_q, write_d;
    logic        valid_q, valid_d;
    logic        err_q, err_d;
    logic [1:0]  off_q, off_d;
    logic [1:0]  size_q, size_d;
    logic        sgn_q, sgn_d;

    logic        accept;
    logic        illegal;
    logic [3:0]  req_be;
    logic [31:0] req_wd;
    logic [7:0]  rd_byte;
    logic [15:0] rd_half;
    logic [31:0] rd_ext;

    assign bus.req_ready  = (state_q == IDLE) && !reset;
    assign accept         = bus.req_valid && bus.req_ready;
    assign bus.address    = addr_q;
    assign bus.byteenable = be_q;
    assign bus.writedata  = wdata_q;
    assign bus.read       = read_q;
    assign bus.write      = write_q;
    assign bus.resp_valid = valid_q;
    assign bus.resp_rdata = rdata_q;
    assign bus.resp_err   = err_q;
    assign dbg_state      = state_q;

    // Lane enables and lane-replicated store data for the incoming request.
    always_comb begin
        req_be  = 4'b0000;
        req_wd  = bus.req_wdata;
        illegal = 1'b1;
        case (bus.req_size)
            2'd0: begin
                req_be  = 4'b0001 << bus.req_addr[1:0];
                req_wd  = {4{bus.req_wdata[7:0]}};
                illegal = 1'b0;
            end
            2'd1: begin
                req_be  = bus.req_addr[1] ? 4'b1100 : 4'b0011;
                req_wd  = {2{bus.req_wdata[15:0]}};
                illegal = bus.req_addr[0];
            end
            2'd2: begin
                req_be  = 4'b1111;
                req_wd  = bus.req_wdata;
                illegal = (bus.req_addr[1:0] != 2'b00);
            end
            default: begin
                req_be  = 4'b0000;
                req_wd  = bus.req_wdata;
                illegal = 1'b1;
            end
        endcase
    end

    // Load extraction uses the lane offset and size captured at acceptance.
    always_comb begin
        rd_byte = bus.readdata[{off_q, 3'b000} +: 8];
        rd_half = off_q[1] ? bus.readdata[31:16] : bus.readdata[15:0];
        case (size_q)
            2'd0:    rd_ext = {{24{sgn_q & rd_byte[7]}}, rd_byte};
            2'd1:    rd_ext = {{16{sgn_q & rd_half[15]}}, rd_half};
            default: rd_ext = bus.readdata;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        be_d    = be_q;
        read_d  = read_q;
        write_d = write_q;
        off_d   = off_q;
        size_d  = size_q;
        sgn_d   = sgn_q;
        valid_d = 1'b0;
        err_d   = 1'b0;
        rdata_d = 32'h0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    addr_d  = {bus.req_addr[31:2], 2'b00};
                    be_d    = req_be;
                    wdata_d = req_wd;
                    off_d   = bus.req_addr[1:0];
                    size_d  = bus.req_size;
                    sgn_d   = bus.req_signed;
                    if (illegal) begin
                        state_d = RESP_ERR;
                        valid_d = 1'b1;
                        err_d   = 1'b1;
                    end else if (bus.req_write) begin
                        state_d = WR_REQ;
                        write_d = 1'b1;
                    end else begin
                        state_d = RD_REQ;
                        read_d  = 1'b1;
                    end
                end
            end
            RD_REQ: begin
                if (!bus.waitrequest) begin
                    state_d = RD_DATA;
                    read_d  = 1'b0;
                    cnt_d   = 3'(READ_LATENCY);
                end
            end
            RD_DATA: begin
                // readdata is valid on the edge where the latency count has run down to 1.
                if (cnt_q <= 3'd1) begin
                    state_d = IDLE;
                    cnt_d   = 3'd0;
                    valid_d = 1'b1;
                    rdata_d = rd_ext;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            WR_REQ: begin
                if (!bus.waitrequest) begin
                    state_d = IDLE;
                    write_d = 1'b0;
                    valid_d = 1'b1;
                end
            end
            RESP_ERR: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                read_d  = 1'b0;
                write_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= 3'd0;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            rdata_q <= 32'h0;
            be_q    <= 4'b0000;
            read_q  <= 1'b0;
            write_q <= 1'b0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            off_q   <= 2'b00;
            size_q  <= 2'b00;
            sgn_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            be_q    <= be_d;
            read_q  <= read_d;
            write_q <= write_d;
            valid_q <= valid_d;
            err_q   <= err_d;
            off_q   <= off_d;
            size_q  <= size_d;
            sgn_q   <= sgn_d;
        end
    end

endmodule
